// File: rtl/atari_clk_pkg.sv
// Shared types and default constants for the Atari clock/reset controller.
package atari_clk_pkg;

  // Controller phases: wait for a qualified PLL lock, hold reset, then run.
  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2
  } clk_state_t;

  // 28.636364 MHz / 16 = 1.79 MHz fast CPU cycle, / 24 = 1.19 MHz slow cycle.
  localparam int DIV_FAST_DEF   = 16;
  localparam int DIV_SLOW_DEF   = 24;
  localparam int RESET_HOLD_DEF = 256;

  // Width of a counter that must represent 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/atari_clk_ctrl_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level; clears on reset.
module sync_bit (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/atari_clk_ctrl.sv
// Clock-enable and reset controller: qualifies PLL lock, holds downstream
// reset for RESET_HOLD cycles, then generates video-rate enables and the
// variable-length (fast/slow) CPU cycle enables with pause support.
//
// Handshake note: cpu_slow and cpu_pause are level requests with no ready;
// both are sampled only at a CPU cycle boundary (ce_cpu cycle), and
// cpu_pause is additionally re-sampled every cycle while paused.
module atari_clk_ctrl
  import atari_clk_pkg::*;
#(
  parameter int RESET_HOLD = RESET_HOLD_DEF,
  parameter int DIV_FAST   = DIV_FAST_DEF,
  parameter int DIV_SLOW   = DIV_SLOW_DEF
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pll_locked,
  input  logic cpu_slow,
  input  logic cpu_pause,
  output logic sys_reset,
  output logic ce_14m,
  output logic ce_7m,
  output logic ce_3m58,
  output logic ce_cpu_half,
  output logic ce_cpu,
  output logic cpu_is_slow
);

  localparam int HW = cnt_width(RESET_HOLD);
  localparam int CW = cnt_width((DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST);

  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
  localparam logic [CW-1:0] FAST_LAST = CW'(DIV_FAST - 1);
  localparam logic [CW-1:0] SLOW_LAST = CW'(DIV_SLOW - 1);
  localparam logic [CW-1:0] FAST_MID  = CW'(DIV_FAST / 2 - 1);
  localparam logic [CW-1:0] SLOW_MID  = CW'(DIV_SLOW / 2 - 1);

  clk_state_t    state;
  clk_state_t    state_next;
  logic          lock_s;
  logic [HW-1:0] hold_cnt;
  logic [2:0]    div_cnt;
  logic [CW-1:0] cpu_cnt;
  logic          cpu_paused;
  logic          run;
  logic          run_keep;
  logic          cpu_boundary;
  logic          cpu_mid;
  logic          sys_reset_nxt;

  sync_bit u_lock_sync (
    .clk   (clk_sys),
    .reset (reset),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // State register together with the registered sys_reset output.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ST_WAIT_LOCK;
      sys_reset <= 1'b1;
    end else begin
      state     <= state_next;
      sys_reset <= sys_reset_nxt;
    end
  end

  // Next-state: any loss of synchronized lock drops back to WAIT_LOCK.
  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT_LOCK: if (lock_s) state_next = ST_HOLD;
      ST_HOLD: begin
        if (!lock_s)                    state_next = ST_WAIT_LOCK;
        else if (hold_cnt == HOLD_LAST) state_next = ST_RUN;
      end
      ST_RUN:  if (!lock_s) state_next = ST_WAIT_LOCK;
      default: state_next = ST_WAIT_LOCK;
    endcase
  end

  // Output decode: enables come straight from registered counters.
  always_comb begin
    run           = (state == ST_RUN);
    run_keep      = run && (state_next == ST_RUN);
    sys_reset_nxt = (state_next != ST_RUN);
    cpu_boundary  = (cpu_cnt == (cpu_is_slow ? SLOW_LAST : FAST_LAST));
    cpu_mid       = (cpu_cnt == (cpu_is_slow ? SLOW_MID : FAST_MID));
    ce_14m        = run && div_cnt[0];
    ce_7m         = run && (div_cnt[1:0] == 2'b11);
    ce_3m58       = run && (div_cnt == 3'b111);
    ce_cpu        = run && !cpu_paused && cpu_boundary;
    ce_cpu_half   = run && !cpu_paused && cpu_mid;
  end

  // Hold counter runs only in HOLD, so it is zero on every HOLD entry.
  always_ff @(posedge clk_sys) begin
    if (reset || state != ST_HOLD) hold_cnt <= '0;
    else                           hold_cnt <= hold_cnt + HW'(1);
  end

  // Video divider: zero outside RUN and on the first RUN cycle.
  always_ff @(posedge clk_sys) begin
    if (reset || !run_keep) div_cnt <= 3'd0;
    else                    div_cnt <= div_cnt + 3'd1;
  end

  // CPU cycle counter; speed and pause are latched only at the boundary.
  always_ff @(posedge clk_sys) begin
    if (reset || !run_keep) begin
      cpu_cnt     <= '0;
      cpu_is_slow <= 1'b0;
      cpu_paused  <= 1'b0;
    end else if (cpu_paused) begin
      cpu_cnt    <= '0;
      cpu_paused <= cpu_pause;
    end else if (cpu_boundary) begin
      cpu_cnt     <= '0;
      cpu_is_slow <= cpu_slow;
      cpu_paused  <= cpu_pause;
    end else begin
      cpu_cnt <= cpu_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_atari_clk_ctrl.sv
// Bench for atari_clk_ctrl: cycle model of the controller's rules compared
// every cycle, plus directed scenarios with hand-computed cycle numbers.
module tb_atari_clk_ctrl;

  localparam int RH = 256;
  localparam int DF = 16;
  localparam int DS = 24;

  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic pll_locked = 1'b0;
  logic cpu_slow = 1'b0;
  logic cpu_pause = 1'b0;
  logic sys_reset, ce_14m, ce_7m, ce_3m58, ce_cpu_half, ce_cpu, cpu_is_slow;

  int total = 0;
  int bad = 0;
  int rc = 0;

  atari_clk_ctrl #(.RESET_HOLD(RH), .DIV_FAST(DF), .DIV_SLOW(DS)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .cpu_slow    (cpu_slow),
    .cpu_pause   (cpu_pause),
    .sys_reset   (sys_reset),
    .ce_14m      (ce_14m),
    .ce_7m       (ce_7m),
    .ce_3m58     (ce_3m58),
    .ce_cpu_half (ce_cpu_half),
    .ce_cpu      (ce_cpu),
    .cpu_is_slow (cpu_is_slow)
  );

  // Clock
  always #5 clk_sys = ~clk_sys;

  task automatic cmp(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t rc=%0d got=%b want=%b", nm, $time, rc, act, exp);
    end
  endtask

  task automatic cmp_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  // Advance to the falling edge of run-relative cycle t.
  task automatic at(input int t);
    while (rc < t) begin
      @(negedge clk_sys);
      rc++;
    end
  endtask

  // Behavioural model: phase, age since RUN entry, position in CPU cycle.
  int m_s1 = 0, m_s2 = 0, m_mode = 0, m_hold = 0, m_age = 0;
  int m_pos = 0, m_len = DF, m_paused = 0;
  bit m_valid = 0;

  always @(posedge clk_sys) begin : model
    int ls;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_mode = 0; m_hold = 0; m_age = 0;
      m_pos = 0; m_len = DF; m_paused = 0; m_valid = 1;
    end else begin
      ls = m_s2;
      m_s2 = m_s1;
      m_s1 = int'(pll_locked);
      case (m_mode)
        0: if (ls != 0) begin m_mode = 1; m_hold = 0; end
        1: begin
          if (ls == 0) m_mode = 0;
          else if (m_hold == RH - 1) begin
            m_mode = 2; m_age = 0; m_pos = 0; m_len = DF; m_paused = 0;
          end else m_hold++;
        end
        default: begin
          if (ls == 0) m_mode = 0;
          else begin
            m_age++;
            if (m_paused != 0) m_paused = int'(cpu_pause);
            else if (m_pos == m_len - 1) begin
              m_pos = 0;
              m_len = cpu_slow ? DS : DF;
              m_paused = int'(cpu_pause);
            end else m_pos++;
          end
        end
      endcase
    end
  end

  // Scoreboard compare on every falling edge once the model is reset.
  always @(negedge clk_sys) begin
    bit r;
    if (m_valid) begin
      r = (m_mode == 2);
      cmp("sys_reset",   sys_reset,   !r);
      cmp("ce_14m",      ce_14m,      r && (m_age % 2 == 1));
      cmp("ce_7m",       ce_7m,       r && (m_age % 4 == 3));
      cmp("ce_3m58",     ce_3m58,     r && (m_age % 8 == 7));
      cmp("ce_cpu_half", ce_cpu_half, r && m_paused == 0 && m_pos == m_len / 2 - 1);
      cmp("ce_cpu",      ce_cpu,      r && m_paused == 0 && m_pos == m_len - 1);
      cmp("cpu_is_slow", cpu_is_slow, r && m_len == DS);
    end
  end

  initial begin
    int n, cnt, first_c, first_h, last_c, n14, n358;
    bit got;
    // Reset and idle without lock
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    cmp("rst_sys_reset", sys_reset, 1'b1);
    cmp("rst_ce_14m", ce_14m, 1'b0);
    cmp("rst_is_slow", cpu_is_slow, 1'b0);
    repeat (5) @(negedge clk_sys);
    cmp("nolock_sys_reset", sys_reset, 1'b1);

    // Lock rises: sys_reset falls 2 sync + 256 hold + 1 FSM cycles later
    pll_locked = 1'b1;
    n = 0;
    got = 0;
    while (n < 400 && !got) begin
      @(negedge clk_sys);
      n++;
      if (sys_reset === 1'b0) got = 1;
    end
    cmp_int("lock_to_run", n, 259);
    rc = 0;
    cmp("run0_ce_14m", ce_14m, 1'b0);
    at(1);
    cmp("run1_ce_14m", ce_14m, 1'b1);

    // 64 fast cycles: pulses at 15,31,47,63, halves 8 earlier
    cnt = 0; first_c = -1; first_h = -1; last_c = -1;
    for (int i = 0; i < 64; i++) begin
      at(i);
      if (ce_cpu === 1'b1) begin
        cnt++;
        if (first_c < 0) first_c = i;
        last_c = i;
      end
      if (ce_cpu_half === 1'b1 && first_h < 0) first_h = i;
    end
    cmp_int("fast_cpu_count", cnt, 4);
    cmp_int("fast_first_cpu", first_c, 15);
    cmp_int("fast_first_half", first_h, 7);
    cmp_int("fast_last_cpu", last_c, 63);

    // Slow request mid-cycle (pos 5 at rc 69): current stays 16 long
    at(69); cpu_slow = 1'b1;
    at(79); cmp("slow_cur_end", ce_cpu, 1'b1);
    cmp("slow_not_yet", cpu_is_slow, 1'b0);
    at(80); cmp("slow_latched", cpu_is_slow, 1'b1);
    at(91); cmp("slow_half_11", ce_cpu_half, 1'b1);
    at(95); cmp("slow_no_16", ce_cpu, 1'b0);
    at(100); cpu_slow = 1'b0;
    at(103); cmp("slow_end_24", ce_cpu, 1'b1);

    // Pause for 40 cycles: boundary at 119, frozen 120..144
    at(104); cpu_pause = 1'b1;
    at(119); cmp("pause_last_cpu", ce_cpu, 1'b1);
    cnt = 0; n14 = 0; n358 = 0;
    for (int i = 120; i < 160; i++) begin
      at(i);
      if (i == 144) cpu_pause = 1'b0;
      if (ce_cpu === 1'b1) cnt++;
      if (ce_14m === 1'b1) n14++;
      if (ce_3m58 === 1'b1) n358++;
    end
    cmp_int("pause_no_cpu", cnt, 0);
    cmp_int("pause_ce_14m", n14, 20);
    cmp_int("pause_ce_3m58", n358, 5);
    at(160); cmp("pause_resume", ce_cpu, 1'b1);

    // One-cycle lock glitch mid-RUN
    at(170); pll_locked = 1'b0;
    at(171); pll_locked = 1'b1;
    at(172); cmp("glitch_still_run", sys_reset, 1'b0);
    at(173); cmp("glitch_reset", sys_reset, 1'b1);
    at(429); cmp("rehold_end", sys_reset, 1'b1);
    at(430); cmp("rehold_run", sys_reset, 1'b0);

    // Second glitch, then external reset at hold count 100
    at(450); pll_locked = 1'b0;
    at(451); pll_locked = 1'b1;
    at(554); reset = 1'b1;
    at(555); reset = 1'b0;
    cmp("hreset_sys_reset", sys_reset, 1'b1);
    at(813); cmp("hreset_hold_end", sys_reset, 1'b1);
    at(814); cmp("hreset_run", sys_reset, 1'b0);

    // Reset mid-RUN while in a slow cycle
    cpu_slow = 1'b1;
    at(840); cmp("mrun_is_slow", cpu_is_slow, 1'b1);
    reset = 1'b1;
    at(841); reset = 1'b0;
    cmp("mrun_sys_reset", sys_reset, 1'b1);
    cmp("mrun_is_slow0", cpu_is_slow, 1'b0);
    cmp("mrun_ce_14m", ce_14m, 1'b0);
    at(850);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atari_clk_ctrl.md
ATARI_CLK_CTRL -- requirements
Module: atari_clk_ctrl

Interface
REQ-001 SHALL have parameter RESET_HOLD, default 256, meaning clk_sys cycles reset is held after lock is qualified.
REQ-002 SHALL have parameter DIV_FAST, default 16, meaning clk_sys cycles per fast CPU cycle (1.79 MHz).
REQ-003 SHALL have parameter DIV_SLOW, default 24, meaning clk_sys cycles per slow CPU cycle (1.19 MHz).
REQ-004 clk_sys  in  1  28.636364 MHz system clock, the only clock.
REQ-005 reset  in  1  synchronous, active-high external reset request.
REQ-006 pll_locked  in  1  PLL lock, asynchronous to clk_sys.
REQ-007 cpu_slow  in  1  request slow CPU cycle (TIA/RIOT access).
REQ-008 cpu_pause  in  1  freeze CPU enables at next cycle boundary.
REQ-009 sys_reset  out  1  synchronous reset for all downstream logic.
REQ-010 ce_14m  out  1  one-cycle enable, 14.318182 MHz rate.
REQ-011 ce_7m  out  1  one-cycle enable, 7.159091 MHz rate.
REQ-012 ce_3m58  out  1  one-cycle enable, 3.579545 MHz rate.
REQ-013 ce_cpu_half  out  1  one-cycle enable at CPU phi2 rising point.
REQ-014 ce_cpu  out  1  one-cycle enable at CPU cycle end.
REQ-015 cpu_is_slow  out  1  current CPU cycle is a slow cycle.

Function
REQ-016 pll_locked SHALL pass a 2-flop synchronizer; only lock_s (synchronized) is used.
REQ-017 FSM states: WAIT_LOCK, HOLD, RUN.
REQ-018 WAIT_LOCK -> HOLD when lock_s=1; hold counter cleared on entry.
REQ-019 HOLD -> RUN when hold counter reaches RESET_HOLD-1; sys_reset deasserts in the first RUN cycle.
REQ-020 HOLD or RUN -> WAIT_LOCK the cycle after lock_s=0; sys_reset asserts that cycle.
REQ-021 sys_reset SHALL be 1 in WAIT_LOCK and HOLD, 0 in RUN, registered output.
REQ-022 3-bit div_cnt SHALL be 0 in non-RUN states and increment modulo 8 each RUN cycle.
REQ-023 ce_14m=1 when div_cnt[0]=1; ce_7m=1 when div_cnt[1:0]=3; ce_3m58=1 when div_cnt=7; all registered-equivalent, 0 outside RUN.
REQ-024 cpu_cnt SHALL be 0 outside RUN and count 0..len-1, len=DIV_SLOW if cpu_is_slow else DIV_FAST.
REQ-025 ce_cpu_half=1 when cpu_cnt=len/2-1; ce_cpu=1 when cpu_cnt=len-1.
REQ-026 cpu_is_slow SHALL load cpu_slow only at cpu_cnt=len-1 (boundary); mid-cycle changes of cpu_slow have no effect on current cycle.
REQ-027 cpu_pause sampled at boundary: if 1, cpu_cnt holds 0 and ce_cpu/ce_cpu_half stay 0 until cpu_pause=0; div_cnt enables unaffected.
REQ-028 First RUN cycle: div_cnt=0, cpu_cnt=0, cpu_is_slow=0.
REQ-029 Lock glitch of one clk_sys cycle after synchronization SHALL still force WAIT_LOCK and full RESET_HOLD re-count.

Reset
REQ-030 reset=1 SHALL force WAIT_LOCK, sys_reset=1, all counters 0, all ce_* 0, cpu_is_slow=0 on next edge, including mid-RUN and mid-HOLD.
REQ-031 Synchronizer flops SHALL clear on reset; no asynchronous reset anywhere.

Structure
REQ-032 FSM state enum and DIV_FAST/DIV_SLOW default constants SHALL live in the shared atari_clk_pkg package.
REQ-033 The 2-flop synchronizer SHALL be the sub-module sync_bit; all else inline.

Verification
REQ-034 lock rises at t0 -> sys_reset falls exactly 2+RESET_HOLD(256) cycles later (+1 FSM register), first ce_14m one cycle after RUN entry.
REQ-035 RUN, cpu_slow=0 for 64 cycles -> 4 ce_cpu pulses 16 apart, ce_cpu_half 8 cycles before each.
REQ-036 cpu_slow toggled to 1 at cpu_cnt=5 -> current cycle still 16 long, next 24 long with ce_cpu_half at cnt=11.
REQ-037 cpu_pause=1 for 40 cycles -> no ce_cpu, ce_14m continues every 2 cycles, ce_3m58 every 8.
REQ-038 pll_locked low 1 cycle mid-RUN -> sys_reset=1 within 3 cycles, re-hold 256 cycles.
REQ-039 reset pulse mid-HOLD at count 100 -> hold restarts, sys_reset held, all ce_* 0.
